// File: rtl/tick_timer_if.sv
// rtl/tick_timer_if.sv - interval handshake bundle between a controller and tick_timer
//
// Signals:
//   start       controller -> timer  request to begin an interval
//   load_value  controller -> timer  interval length in ticks, captured with start
//   abort       controller -> timer  cancel a running interval
//   tick        timer -> controller  one-cycle pulse per rising edge of the selected tap
//   busy        timer -> controller  interval running
//   done        timer -> controller  one-cycle pulse on normal completion
//   remaining   timer -> controller  ticks left in the current interval
interface tick_timer_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] load_value;
    logic             abort;
    logic             tick;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] remaining;

    modport master (
        output start, load_value, abort,
        input  tick, busy, done, remaining
    );

    modport slave (
        input  start, load_value, abort,
        output tick, busy, done, remaining
    );
endinterface

// File: rtl/tick_timer.sv
// rtl/tick_timer.sv - divided-clock tap edge detector driving a loadable tick down-counter
//
// Ports:
//   clock           system clock, all state on posedge
//   reset_n         asynchronous active-low reset
//   divided_clocks  divider output bus, bit k toggles every 2^k clocks
//   tap_sel         selects the divided_clocks bit used as tick source
//   ctl             tick_timer_if.slave: start/load_value/abort in, tick/busy/done/remaining out
module tick_timer #(
    parameter int TAP_W = 5,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [31:0]      divided_clocks,
    input  logic [TAP_W-1:0] tap_sel,
    tick_timer_if.slave      ctl
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] remaining_q;
    logic [CNT_W-1:0] remaining_nxt;

    logic             tap_q;
    logic             tap_d;
    logic [TAP_W-1:0] sel_q;
    logic             tick;

    // Divided clocks are only ever sampled as data. When the tap selection
    // changes, both history bits load the new tap so the switch itself can
    // never look like a rising edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tap_q <= 1'b0;
            tap_d <= 1'b0;
            sel_q <= '0;
        end else begin
            sel_q <= tap_sel;
            tap_q <= divided_clocks[tap_sel];
            if (tap_sel != sel_q) begin
                tap_d <= divided_clocks[tap_sel];
            end else begin
                tap_d <= tap_q;
            end
        end
    end

    assign tick = tap_q & ~tap_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            remaining_q <= '0;
        end else begin
            state       <= state_nxt;
            remaining_q <= remaining_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining_q;
        case (state)
            IDLE: begin
                // abort has nothing to cancel here, so only start matters
                if (ctl.start) begin
                    if (ctl.load_value != '0) begin
                        remaining_nxt = ctl.load_value;
                        state_nxt     = RUN;
                    end else begin
                        state_nxt     = DONE;
                    end
                end
            end
            RUN: begin
                if (ctl.abort) begin
                    remaining_nxt = '0;
                    state_nxt     = IDLE;
                end else if (tick && (remaining_q != '0)) begin
                    remaining_nxt = remaining_q - 1'b1;
                    if (remaining_q == CNT_W'(1)) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                remaining_nxt = '0;
                state_nxt     = IDLE;
            end
            default: begin
                remaining_nxt = '0;
                state_nxt     = IDLE;
            end
        endcase
    end

    assign ctl.tick      = tick;
    assign ctl.busy      = (state == RUN);
    assign ctl.done      = (state == DONE);
    assign ctl.remaining = remaining_q;

endmodule

// File: doc/tick_timer.md
Name: tick_timer

Overview:
- Consumes the 32-bit `divided_clocks` bus produced by the clock divider.
- Selects one tap and converts its rising edges into single-cycle `tick` enables in the `clock` domain.
- Runs a loadable down-counter of ticks with a start/busy/done handshake.
- Used by the elevator control logic for door-open and floor-travel intervals, without using divided clocks as clocks.

Parameters:
- TAP_W, 5: width of `tap_sel`; selects bit 0..31 of `divided_clocks`.
- CNT_W, 8: width of `load_value` and `remaining`; interval length in ticks.

Ports:
- clock, input, 1: system clock; all state updates on posedge.
- reset_n, input, 1: asynchronous, active-low reset.
- divided_clocks, input, 32: divider output bus; bit k toggles every 2^k clock cycles.
- tap_sel, input, TAP_W: selects the `divided_clocks` bit used as the tick source.
- start, input, 1: request to begin an interval; sampled in IDLE only.
- load_value, input, CNT_W: interval length in ticks; captured with `start`.
- abort, input, 1: cancel a running interval.
- tick, output, 1: one-cycle pulse per rising edge of the selected tap.
- busy, output, 1: high while the interval is running.
- done, output, 1: one-cycle pulse when the interval completes normally.
- remaining, output, CNT_W: ticks left in the current interval.

Behaviour:
- This block is clocked by `clock` and has an asynchronous, active-low reset `reset_n`.
- Reset (`reset_n`=0, asynchronous) forces:
  - state=IDLE;
  - tap_q=0, tap_d=0, sel_q=0;
  - tick=0, busy=0, done=0, remaining=0.
- Reset takes effect mid-interval with no `done` pulse.
- Edge detector:
  - Each cycle: sel_q<=tap_sel; tap_q<=divided_clocks[tap_sel]; tap_d<=tap_q.
  - tick = tap_q & ~tap_d, a registered-input combinational output.
  - A 0->1 on the selected bit sampled at edge N gives tick high during the cycle after edge N+1 minus one, i.e. tick is high for exactly the one cycle following the sample where tap_q rises. Latency from the bus change to tick is 1 clock.
- Tap change: when tap_sel != sel_q, both tap_q and tap_d load divided_clocks[tap_sel]. No spurious tick is generated on that cycle or the next.
- Tap 0: tick every 2 cycles. Tap k: tick every 2^(k+1) cycles.
- FSM states are IDLE, RUN and DONE. Priority within each state: abort > start > tick.
- IDLE:
  - `start` with load_value != 0: remaining<=load_value, go to RUN.
  - `start` with load_value == 0: go to DONE directly; remaining stays 0.
  - `abort` in IDLE: no effect.
- RUN:
  - busy=1.
  - `abort`: remaining<=0, go to IDLE, no done.
  - Else on tick: remaining<=remaining-1. If remaining==1, go to DONE.
  - `start` is ignored in RUN. `load_value` is not re-sampled.
- DONE:
  - done=1 for exactly one cycle, busy=0, remaining=0.
  - Unconditionally returns to IDLE.
  - `start` in DONE is ignored and must be re-asserted in IDLE.
- Outputs `busy` and `done` are decoded from the registered state; they are never both high.
- The `tick` output runs freely regardless of FSM state.
- `remaining` never wraps below 0. The decrement only occurs in RUN with remaining >= 1.

Test Plan:
- Reset mid-run: load 5 on tap 2, assert reset_n=0 after 2 ticks. Outputs go to 0 immediately (async), no done pulse, and the FSM is in IDLE after release.
- Tap 0 ticks: drive divided_clocks as a free-running counter with tap_sel=0. tick pulses every 2nd cycle, 1 cycle wide. Switch to tap_sel=3: no tick for 2 cycles, then a tick every 16 cycles.
- Normal interval: tap_sel=1, start with load_value=3. Expect:
  - busy=1 the next cycle;
  - remaining steps 3->2->1->0 on successive ticks;
  - done high for one cycle right after the 3rd tick;
  - busy=0 and done=0 afterwards.
- Zero length: start with load_value=0. done pulses 1 cycle later, busy never asserts, remaining=0.
- Abort vs tick: load 4, and assert abort in the same cycle as the 2nd tick. remaining becomes 0, state is IDLE, no done, abort wins.
- Ignored start: during RUN with remaining=2, pulse start with load_value=9. The interval completes after 2 more ticks and remaining never shows 9. A start held high through DONE produces no restart until the IDLE cycle.
